// File: rtl/alu_sequencer_if.sv
// Instruction handshake, ALU control and status bus for the ALU sequencer.
interface alu_sequencer_if;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic        resume;
  logic [7:0]  alu_opcode;
  logic        alu_carry_in;
  logic [4:0]  alu_flags;
  logic [3:0]  rdest_addr;
  logic [3:0]  rsrc_addr;
  logic [15:0] imm;
  logic        b_sel;
  logic        reg_we;
  logic [4:0]  psr;
  logic        branch_taken;
  logic [15:0] branch_disp;
  logic        illegal;
  logic        halted;

  modport master (
    output instr_valid, instr, resume, alu_flags,
    input  instr_ready, alu_opcode, alu_carry_in, rdest_addr, rsrc_addr, imm,
           b_sel, reg_we, psr, branch_taken, branch_disp, illegal, halted
  );

  modport slave (
    input  instr_valid, instr, resume, alu_flags,
    output instr_ready, alu_opcode, alu_carry_in, rdest_addr, rsrc_addr, imm,
           b_sel, reg_we, psr, branch_taken, branch_disp, illegal, halted
  );
endinterface

// File: rtl/alu_sequencer.sv
// Four-state instruction sequencer: captures an instruction, decodes it into ALU
// controls, executes one cycle (writeback / flags / branch), and supports WAIT/HALT.
module alu_sequencer (
  input  logic            clk,
  input  logic            reset,
  alu_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, DECODE, EXEC, HALT} state_t;
  state_t state, state_nx;

  logic [15:0] instr_q;
  logic [7:0]  opcode_q;
  logic [3:0]  rdest_q, rsrc_q;
  logic [15:0] imm_q, disp_q;
  logic        b_sel_q, branch_q, cmp_q, psr_upd_q, bad_q;
  logic [4:0]  psr_q;

  logic [3:0]  hi, ext;
  logic        d_imm_form, d_shift_imm, d_sext;
  logic [7:0]  d_opcode;
  logic [15:0] d_imm;
  logic        d_cmp, d_psr_upd, d_bad;
  logic        cond_true, flags_bad;

  // Register forms (hi=0000): ext 0001 CMP, 0110 CMPU, 0101 ADD, 0111 ADDC,
  // 1001 SUB, 1010 SUBC. Immediate 0110 is CMPUI, 1011 is CMPI.
  always_comb begin
    hi          = instr_q[15:12];
    ext         = instr_q[7:4];
    d_imm_form  = hi inside {4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0110,
                             4'b0111, 4'b1001, 4'b1010, 4'b1011, 4'b1111};
    d_shift_imm = (hi == 4'b1000) && (ext[3:2] == 2'b00);
    d_sext      = hi inside {4'b0101, 4'b0111, 4'b1001, 4'b1010, 4'b1011};
    d_bad       = hi inside {4'b0100, 4'b1101, 4'b1110};
    d_opcode    = {hi, d_imm_form ? 4'b0000 : ext};
    d_imm       = '0;
    if (d_imm_form)
      d_imm = d_sext ? {{8{instr_q[7]}}, instr_q[7:0]} : {8'h00, instr_q[7:0]};
    else if (d_shift_imm)
      d_imm = {12'h000, instr_q[3:0]};
    if (d_imm_form) begin
      d_cmp     = hi inside {4'b1011, 4'b0110};
      d_psr_upd = hi inside {4'b0101, 4'b0110, 4'b0111, 4'b1001, 4'b1010, 4'b1011};
    end else begin
      d_cmp     = (hi == 4'b0000) && (ext inside {4'b0001, 4'b0110});
      d_psr_upd = (hi == 4'b0000) &&
                  (ext inside {4'b0001, 4'b0101, 4'b0110, 4'b0111, 4'b1001, 4'b1010});
    end
  end

  // Branch condition over psr {C,L,F,Z,N}; cond is held in rdest_q.
  always_comb begin
    cond_true = 1'b0;
    case (rdest_q)
      4'h0: cond_true =  psr_q[1];
      4'h1: cond_true = !psr_q[1];
      4'h2: cond_true =  psr_q[4];
      4'h3: cond_true = !psr_q[4];
      4'h4: cond_true =  psr_q[3];
      4'h5: cond_true = !psr_q[3];
      4'h6: cond_true =  psr_q[0];
      4'h7: cond_true = !psr_q[0];
      4'h8: cond_true =  psr_q[2];
      4'h9: cond_true = !psr_q[2];
      4'hA: cond_true = !psr_q[3] && !psr_q[1];
      4'hB: cond_true =  psr_q[3] ||  psr_q[1];
      4'hC: cond_true = !psr_q[0] && !psr_q[1];
      4'hD: cond_true =  psr_q[0] ||  psr_q[1];
      4'hE: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  assign flags_bad = (bus.alu_flags == 5'b11111);

  always_comb begin
    state_nx         = state;
    bus.reg_we       = 1'b0;
    bus.illegal      = 1'b0;
    bus.branch_taken = 1'b0;
    case (state)
      IDLE:   if (bus.instr_valid) state_nx = DECODE;
      DECODE: state_nx = (instr_q == 16'h0000) ? HALT : EXEC;
      EXEC: begin
        state_nx = IDLE;
        // Strobes are combinational in EXEC, so a reset arriving here must mask them.
        if (!reset) begin
          if (bad_q)                  bus.illegal      = 1'b1;
          else if (branch_q)          bus.branch_taken = cond_true;
          else if (flags_bad)         bus.illegal      = 1'b1;
          else if (!cmp_q)            bus.reg_we       = 1'b1;
        end
      end
      HALT:   if (bus.resume) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      instr_q   <= '0;
      opcode_q  <= '0;
      rdest_q   <= '0;
      rsrc_q    <= '0;
      imm_q     <= '0;
      disp_q    <= '0;
      b_sel_q   <= 1'b0;
      branch_q  <= 1'b0;
      cmp_q     <= 1'b0;
      psr_upd_q <= 1'b0;
      bad_q     <= 1'b0;
      psr_q     <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.instr_valid)
        instr_q <= bus.instr;
      if (state == DECODE) begin
        opcode_q  <= d_opcode;
        rdest_q   <= instr_q[11:8];
        rsrc_q    <= instr_q[3:0];
        imm_q     <= d_imm;
        disp_q    <= {{8{instr_q[7]}}, instr_q[7:0]};
        b_sel_q   <= d_imm_form || d_shift_imm;
        branch_q  <= (hi == 4'b1100);
        cmp_q     <= d_cmp;
        psr_upd_q <= d_psr_upd;
        bad_q     <= d_bad;
      end
      if (state == EXEC && !bad_q && !branch_q && !flags_bad && psr_upd_q)
        psr_q <= bus.alu_flags;
    end
  end

  assign bus.instr_ready  = (state == IDLE);
  assign bus.halted       = (state == HALT);
  assign bus.alu_opcode   = opcode_q;
  assign bus.alu_carry_in = psr_q[4];
  assign bus.rdest_addr   = rdest_q;
  assign bus.rsrc_addr    = rsrc_q;
  assign bus.imm          = imm_q;
  assign bus.b_sel        = b_sel_q;
  assign bus.branch_disp  = disp_q;
  assign bus.psr          = psr_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: vector table through a scoreboard queue,
// plus hand-written WAIT/HALT and reset-in-flight sequences.
module tb_alu_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;

  alu_sequencer_if bus();
  alu_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] instr;
    logic [4:0]  flags;
    logic [7:0]  opcode;
    logic [15:0] imm;
    logic        bsel;
    logic [3:0]  rdest;
    logic [3:0]  rsrc;
    logic [2:0]  strb;   // {reg_we, illegal, branch_taken}
    logic [15:0] disp;
    logic [4:0]  psr;    // psr after the instruction retires
  } vec_t;

  vec_t tbl[18];
  vec_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] strobes();
    return {29'd0, bus.reg_we, bus.illegal, bus.branch_taken};
  endfunction

  task automatic issue(input vec_t v, input int idx);
    vec_t e;
    int unsigned waited;
    exp_q.push_back(v);
    @(posedge clk); #1;
    bus.instr       = v.instr;
    bus.alu_flags   = v.flags;
    bus.instr_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!bus.instr_ready && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    chk($sformatf("v%0d_accept", idx), bus.instr_ready, 1);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_decode_ready", idx), bus.instr_ready, 0);
    chk($sformatf("v%0d_decode_strb", idx), strobes(), 0);
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    chk($sformatf("v%0d_opcode", idx), bus.alu_opcode, e.opcode);
    chk($sformatf("v%0d_imm", idx), bus.imm, e.imm);
    chk($sformatf("v%0d_bsel", idx), bus.b_sel, e.bsel);
    chk($sformatf("v%0d_rdest", idx), bus.rdest_addr, e.rdest);
    chk($sformatf("v%0d_rsrc", idx), bus.rsrc_addr, e.rsrc);
    chk($sformatf("v%0d_strobes", idx), strobes(), e.strb);
    chk($sformatf("v%0d_disp", idx), bus.branch_disp, e.disp);
    @(posedge clk); #1;
    chk($sformatf("v%0d_psr", idx), bus.psr, e.psr);
    chk($sformatf("v%0d_carry", idx), bus.alu_carry_in, e.psr[4]);
    chk($sformatf("v%0d_ready_after", idx), bus.instr_ready, 1);
  endtask

  task automatic go_to_halt(input string tag);
    @(posedge clk); #1;
    bus.instr = 16'h0000; bus.instr_valid = 1'b1;
    @(negedge clk);
    chk({tag, "_accept"}, bus.instr_ready, 1);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_decode_halted"}, bus.halted, 0);
    @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{16'h5AFF, 5'b00000, 8'h50, 16'hFFFF, 1'b1, 4'hA, 4'hF, 3'b100, 16'hFFFF, 5'b00000};
    tbl[1]  = '{16'h0B12, 5'b00010, 8'h01, 16'h0000, 1'b0, 4'hB, 4'h2, 3'b000, 16'h0012, 5'b00010};
    tbl[2]  = '{16'hC005, 5'b00000, 8'hC0, 16'h0000, 1'b0, 4'h0, 4'h5, 3'b001, 16'h0005, 5'b00010};
    tbl[3]  = '{16'hC1F0, 5'b00000, 8'hCF, 16'h0000, 1'b0, 4'h1, 4'h0, 3'b000, 16'hFFF0, 5'b00010};
    tbl[4]  = '{16'hCEF0, 5'b00000, 8'hCF, 16'h0000, 1'b0, 4'hE, 4'h0, 3'b001, 16'hFFF0, 5'b00010};
    tbl[5]  = '{16'h840A, 5'b00000, 8'h80, 16'h000A, 1'b1, 4'h4, 4'hA, 3'b100, 16'h000A, 5'b00010};
    tbl[6]  = '{16'h3100, 5'b00001, 8'h30, 16'h0000, 1'b1, 4'h1, 4'h0, 3'b100, 16'h0000, 5'b00010};
    tbl[7]  = '{16'h0152, 5'b10000, 8'h05, 16'h0000, 1'b0, 4'h1, 4'h2, 3'b100, 16'h0052, 5'b10000};
    tbl[8]  = '{16'hC203, 5'b00000, 8'hC0, 16'h0000, 1'b0, 4'h2, 4'h3, 3'b001, 16'h0003, 5'b10000};
    tbl[9]  = '{16'h7A80, 5'b01000, 8'h70, 16'hFF80, 1'b1, 4'hA, 4'h0, 3'b100, 16'hFF80, 5'b01000};
    tbl[10] = '{16'h2345, 5'b11111, 8'h20, 16'h0045, 1'b1, 4'h3, 4'h5, 3'b010, 16'h0045, 5'b01000};
    tbl[11] = '{16'h4123, 5'b00000, 8'h42, 16'h0000, 1'b0, 4'h1, 4'h3, 3'b010, 16'h0023, 5'b01000};
    tbl[12] = '{16'h6B80, 5'b00100, 8'h60, 16'h0080, 1'b1, 4'hB, 4'h0, 3'b000, 16'hFF80, 5'b00100};
    tbl[13] = '{16'hC8FE, 5'b00000, 8'hCF, 16'h0000, 1'b0, 4'h8, 4'hE, 3'b001, 16'hFFFE, 5'b00100};
    tbl[14] = '{16'hCA01, 5'b00000, 8'hC0, 16'h0000, 1'b0, 4'hA, 4'h1, 3'b001, 16'h0001, 5'b00100};
    tbl[15] = '{16'hCF7F, 5'b00000, 8'hC7, 16'h0000, 1'b0, 4'hF, 4'hF, 3'b000, 16'h007F, 5'b00100};
    tbl[16] = '{16'h9C01, 5'b11111, 8'h90, 16'h0001, 1'b1, 4'hC, 4'h1, 3'b010, 16'h0001, 5'b00100};
    tbl[17] = '{16'h8A45, 5'b00011, 8'h84, 16'h0000, 1'b0, 4'hA, 4'h5, 3'b100, 16'h0045, 5'b00100};

    reset = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0000;
    bus.resume      = 1'b0;
    bus.alu_flags   = 5'b00000;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", bus.instr_ready, 1);
    chk("rst_psr", bus.psr, 0);
    chk("rst_opcode", bus.alu_opcode, 0);
    chk("rst_rdest", bus.rdest_addr, 0);
    chk("rst_rsrc", bus.rsrc_addr, 0);
    chk("rst_imm", bus.imm, 0);
    chk("rst_bsel", bus.b_sel, 0);
    chk("rst_strobes", strobes(), 0);
    chk("rst_disp", bus.branch_disp, 0);
    chk("rst_halted", bus.halted, 0);

    for (int i = 0; i < 18; i++) issue(tbl[i], i);

    // WAIT: halt until resume, no strobes, psr untouched
    go_to_halt("wait");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("wait_halted", bus.halted, 1);
      chk("wait_ready", bus.instr_ready, 0);
      chk("wait_strobes", strobes(), 0);
    end
    chk("wait_psr", bus.psr, 5'b00100);
    @(posedge clk); #1 bus.resume = 1'b1;
    @(posedge clk); #1 bus.resume = 1'b0;
    @(negedge clk);
    chk("resume_halted", bus.halted, 0);
    chk("resume_ready", bus.instr_ready, 1);

    // Reset during EXEC of an ADD that would otherwise set psr to 10000
    @(posedge clk); #1;
    bus.instr = 16'h0152; bus.alu_flags = 5'b10000; bus.instr_valid = 1'b1;
    @(negedge clk);
    chk("rexec_accept", bus.instr_ready, 1);
    @(posedge clk); #1 bus.instr_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("rexec_strobes", strobes(), 0);
    @(posedge clk); #1 reset = 1'b0;
    chk("rexec_psr", bus.psr, 0);
    chk("rexec_ready", bus.instr_ready, 1);
    chk("rexec_opcode", bus.alu_opcode, 0);

    // Reset while halted
    go_to_halt("rhalt");
    @(negedge clk);
    chk("rhalt_halted_before", bus.halted, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("rhalt_halted", bus.halted, 0);
    chk("rhalt_ready", bus.instr_ready, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameters: none; all widths fixed (16-bit instruction/data, 8-bit ALU opcode, 5-bit flags).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 instr_valid / instr[15:0]  input  1/16  instruction offer; instr_ready  output  1  accept when high.
REQ-005 resume  input  1  releases HALT state.
REQ-006 alu_opcode  output  8  opcode to ALU; alu_carry_in  output  1  carry to ALU; alu_flags  input  5  ALU flags ({C,L,F,Z,N}, bit 4..0).
REQ-007 rdest_addr, rsrc_addr  output  4 each  register-file read/write addresses (rdest = ALU A and write target).
REQ-008 imm  output  16  extended immediate; b_sel  output  1  1 = ALU B takes imm, 0 = register rsrc.
REQ-009 reg_we  output  1  one-cycle register write strobe; psr  output  5  processor status register.
REQ-010 branch_taken  output  1  one-cycle pulse; branch_disp  output  16  sign-extended displacement.
REQ-011 illegal  output  1  one-cycle pulse on bad opcode; halted  output  1  high in HALT.

Function
REQ-012 FSM states IDLE, DECODE, EXEC, HALT; instr_ready=1 only in IDLE.
REQ-013 IDLE: instr_valid&instr_ready captures instr into internal register, -> DECODE; else stay.
REQ-014 DECODE: alu_opcode, rdest_addr=instr[11:8], rsrc_addr=instr[3:0], imm, b_sel driven registered and held stable through EXEC; -> EXEC.
REQ-015 alu_opcode = {instr[15:12], instr[7:4]} for register/shift forms; {instr[15:12],4'b0000} for immediate forms.
REQ-016 Immediate forms: instr[15:12] in {0001,0010,0011,0101,0110,0111,1001,1010,1011,1111}, imm from instr[7:0]; shift-immediate: instr[15:12]=1000 and instr[7:4] in {0000..0011}, imm = zero-extended instr[3:0].
REQ-017 Sign-extend instr[7:0] for ADDI(0101), ADDCI(0111), SUBI(1001), SUBCI(1010), CMPI(1011); zero-extend for all others.
REQ-018 EXEC: sample alu_flags; if alu_flags==5'b11111 pulse illegal, no reg_we, psr unchanged; else pulse reg_we except for CMP/CMPI/CMPU/CMPUI; -> IDLE.
REQ-019 psr <= alu_flags in EXEC only for ADD, ADDC, SUB, SUBC, CMP, CMPU (register or immediate); all other ops leave psr unchanged.
REQ-020 alu_carry_in = psr[4] at all times.
REQ-021 Latency: accept at cycle N -> reg_we/illegal/branch_taken at cycle N+2; next accept earliest N+3.
REQ-022 instr==16'h0000 (WAIT): DECODE -> HALT, no writeback, halted=1; resume=1 in HALT -> IDLE next cycle.
REQ-023 Bcond: instr[15:12]=1100, cond=instr[11:8], branch_disp = sign-extended instr[7:0]; no ALU use, no reg_we, psr unchanged.
REQ-024 Conditions (psr bits C4,L3,F2,Z1,N0): 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 L; 0101 !L; 0110 N; 0111 !N; 1000 F; 1001 !F; 1010 !L&!Z; 1011 L|Z; 1100 !N&!Z; 1101 N|Z; 1110 always; 1111 never.
REQ-025 branch_taken pulses in EXEC iff condition true, evaluated on psr value at entry to EXEC.
REQ-026 reg_we, illegal, branch_taken never asserted outside EXEC; at most one per instruction.

Reset
REQ-027 reset overrides all other inputs in any state, including mid-instruction and HALT.
REQ-028 Reset values: state IDLE, instr_ready=1, psr=0, alu_opcode=0, rdest_addr=0, rsrc_addr=0, imm=0, b_sel=0, reg_we=0, branch_taken=0, branch_disp=0, illegal=0, halted=0.
REQ-029 Instruction in DECODE/EXEC when reset asserts SHALL produce no reg_we and no psr update.

Verification
REQ-030 instr=16'h5AFF (ADDI R10,-1), alu_flags=5'b00000 -> alu_opcode=8'h50, imm=16'hFFFF, b_sel=1, reg_we at N+2, psr=0.
REQ-031 instr=16'h0B12 (CMP R11,R2), alu_flags=5'b00010 -> no reg_we, psr=5'b00010; then instr=16'hC005 (BEQ +5) -> branch_taken=1, branch_disp=16'h0005.
REQ-032 psr=5'b00010, instr=16'hC1F0 (BNE -16) -> branch_taken=0; instr=16'hCEF0 -> branch_taken=1, branch_disp=16'hFFF0.
REQ-033 instr=16'h840A (LSHI R4,#10) -> alu_opcode=8'h80, imm=16'h000A, b_sel=1; instr=16'h3100 (ANDI... XORI R1,0) zero-extend -> imm=16'h0000.
REQ-034 instr=16'h0000 -> halted=1, instr_ready=0 until resume pulse, then IDLE; alu_flags=5'b11111 on any op -> illegal pulse, no reg_we.
REQ-035 reset asserted in EXEC of ADD with alu_flags=5'b10000 -> reg_we=0, psr=0, state IDLE next cycle.
